// File: rtl/fp_io_pkg.sv
// Shared types and constants for the pad-side FP adder bridge.
package fp_io_pkg;

    localparam int NIB_W     = 4;
    localparam int DEF_WIDTH = 32;
    localparam int OP_NIBS   = DEF_WIDTH / NIB_W;
    localparam int LOAD_NIBS = 2 * OP_NIBS;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    // Number of nibbles that make up one operand of the given width.
    function automatic int op_nibs(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/pad_strobe_sync.sv
// Two-flop synchronizer for the pad nibble and strobe, plus an edge register
// that turns each strobe rise into a single-cycle pulse.
module pad_strobe_sync
    import fp_io_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NIB_W-1:0] pad_in_i,
    input  logic             pad_stb_i,
    output logic             stb_pulse_o,
    output logic [NIB_W-1:0] nib_sync_o
);

    logic [NIB_W:0] meta_q;
    logic [NIB_W:0] sync_q;
    logic           stb_prev_q;

    // Synchronizer chain and strobe edge history.
    // NOTE: sequential state uses nonblocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q     <= '0;
            sync_q     <= '0;
            stb_prev_q <= 1'b0;
        end else begin
            meta_q     <= {pad_stb_i, pad_in_i};
            sync_q     <= meta_q;
            stb_prev_q <= sync_q[NIB_W];
        end
    end

    // Data comes from the same synchronized stage as the strobe, so it is
    // aligned with the pulse (the host holds it stable around the strobe).
    assign stb_pulse_o = sync_q[NIB_W] & ~stb_prev_q;
    assign nib_sync_o  = sync_q[NIB_W-1:0];

endmodule

// File: rtl/fp_io_bridge.sv
// Pad front end for the FP adder: loads two operands nibble by nibble, issues
// them over valid/ready, captures the result and streams it back out.
module fp_io_bridge
    import fp_io_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [NIB_W-1:0] pad_in_i,
    input  logic             pad_stb_i,
    output logic [NIB_W-1:0] pad_out_o,
    output logic             pad_rdy_o,
    output logic             pad_busy_o,
    output logic             pad_err_o,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    input  logic [WIDTH-1:0] res_i,
    input  logic             res_valid_i,
    output logic             res_ready_o
);

    localparam int OpNibs   = op_nibs(WIDTH);
    localparam int LoadNibs = 2 * OpNibs;
    localparam int CntW     = $clog2(LoadNibs);

    localparam logic [CntW-1:0] LastLoad = CntW'(LoadNibs - 1);
    localparam logic [CntW-1:0] LastRead = CntW'(OpNibs - 1);

    state_t               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   ab_q, ab_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 err_q, err_d;

    logic                 stb_pulse;
    logic [NIB_W-1:0]     nib_sync;

    pad_strobe_sync u_sync (
        .clk_i       (wb_clk_i),
        .rst_ni      (wb_rst_ni),
        .pad_in_i    (pad_in_i),
        .pad_stb_i   (pad_stb_i),
        .stb_pulse_o (stb_pulse),
        .nib_sync_o  (nib_sync)
    );

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= ST_LOAD;
        else            state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:  if (stb_pulse && cnt_q == LastLoad) state_d = ST_ISSUE;
            ST_ISSUE: if (op_ready_i)                     state_d = ST_WAIT;
            ST_WAIT:  if (res_valid_i)                    state_d = ST_READ;
            ST_READ:  if (stb_pulse && cnt_q == LastRead) state_d = ST_LOAD;
            default:                                      state_d = ST_LOAD;
        endcase
    end

    // Datapath next values: nibble counter, operand shifter, result shifter, error flag.
    always_comb begin
        cnt_d = cnt_q;
        ab_d  = ab_q;
        res_d = res_q;
        err_d = err_q;
        unique case (state_q)
            ST_LOAD: begin
                if (stb_pulse) begin
                    ab_d  = {ab_q[2*WIDTH-NIB_W-1:0], nib_sync};
                    cnt_d = (cnt_q == LastLoad) ? '0 : cnt_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                // Strobes while busy are dropped but remembered as an error.
                if (stb_pulse) err_d = 1'b1;
            end
            ST_WAIT: begin
                if (stb_pulse)   err_d = 1'b1;
                if (res_valid_i) res_d = res_i;
            end
            ST_READ: begin
                if (stb_pulse) begin
                    res_d = {res_q[WIDTH-NIB_W-1:0], {NIB_W{1'b0}}};
                    cnt_d = (cnt_q == LastRead) ? '0 : cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    // NOTE: the operand and result registers are reset because they drive
    // outputs that must read zero after reset, not merely to initialize storage.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q <= '0;
            ab_q  <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ab_q  <= ab_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    // Output decode from the current state.
    always_comb begin
        op_valid_o  = (state_q == ST_ISSUE);
        res_ready_o = (state_q == ST_WAIT);
        pad_busy_o  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        pad_rdy_o   = (state_q == ST_READ);
        pad_out_o   = pad_rdy_o ? res_q[WIDTH-1:WIDTH-NIB_W] : '0;
    end

    assign pad_err_o = err_q;
    assign op_a_o    = ab_q[2*WIDTH-1:WIDTH];
    assign op_b_o    = ab_q[WIDTH-1:0];

endmodule

// File: tb/tb_fp_io_bridge.sv
// Directed bench for fp_io_bridge: full operations, backpressure, busy-strobe
// error, mid-load reset, long strobe and early res_valid.
module tb_fp_io_bridge;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic [3:0]  pad_in_i;
    logic        pad_stb_i;
    logic [3:0]  pad_out_o;
    logic        pad_rdy_o;
    logic        pad_busy_o;
    logic        pad_err_o;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic        op_valid_o;
    logic        op_ready_i;
    logic [31:0] res_i;
    logic        res_valid_i;
    logic        res_ready_o;

    int tests = 0;
    int fails = 0;

    fp_io_bridge #(.WIDTH(32)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .pad_in_i    (pad_in_i),
        .pad_stb_i   (pad_stb_i),
        .pad_out_o   (pad_out_o),
        .pad_rdy_o   (pad_rdy_o),
        .pad_busy_o  (pad_busy_o),
        .pad_err_o   (pad_err_o),
        .op_a_o      (op_a_o),
        .op_b_o      (op_b_o),
        .op_valid_o  (op_valid_o),
        .op_ready_i  (op_ready_i),
        .res_i       (res_i),
        .res_valid_i (res_valid_i),
        .res_ready_o (res_ready_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib_at(input logic [63:0] v, input int i);
        return v[63-4*i -: 4];
    endfunction

    // One host nibble: data settles, strobe high 4 clocks, low 4 clocks.
    task automatic send_nibble(input logic [3:0] n, input int high_clks = 4);
        @(negedge wb_clk_i);
        pad_in_i = n;
        repeat (3) @(negedge wb_clk_i);
        pad_stb_i = 1'b1;
        repeat (high_clks) @(negedge wb_clk_i);
        pad_stb_i = 1'b0;
        repeat (4) @(negedge wb_clk_i);
    endtask

    task automatic load_range(input logic [63:0] ab, input int first, input int last);
        for (int i = first; i <= last; i++) send_nibble(nib_at(ab, i));
    endtask

    // Adder returns its result two cycles later, holding valid one cycle.
    task automatic give_result(input logic [31:0] r);
        int n = 0;
        while (!res_ready_o && n < 50) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("res_ready_seen", {63'd0, res_ready_o}, 64'd1);
        repeat (2) @(negedge wb_clk_i);
        res_i = r;
        res_valid_i = 1'b1;
        @(negedge wb_clk_i);
        res_valid_i = 1'b0;
        check("rdy_after_capture", {63'd0, pad_rdy_o}, 64'd1);
        check("busy_after_capture", {63'd0, pad_busy_o}, 64'd0);
    endtask

    task automatic read_result(input logic [31:0] r);
        logic [63:0] rr;
        rr = {r, 32'd0};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rdy_nib%0d", i), {63'd0, pad_rdy_o}, 64'd1);
            check($sformatf("out_nib%0d", i), {60'd0, pad_out_o}, {60'd0, nib_at(rr, i)});
            send_nibble(4'h0);
        end
        check("rdy_after_read", {63'd0, pad_rdy_o}, 64'd0);
        check("out_after_read", {60'd0, pad_out_o}, 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"},   {60'd0, pad_out_o},   64'd0);
        check({tag, "_rdy"},   {63'd0, pad_rdy_o},   64'd0);
        check({tag, "_busy"},  {63'd0, pad_busy_o},  64'd0);
        check({tag, "_err"},   {63'd0, pad_err_o},   64'd0);
        check({tag, "_a"},     {32'd0, op_a_o},      64'd0);
        check({tag, "_b"},     {32'd0, op_b_o},      64'd0);
        check({tag, "_valid"}, {63'd0, op_valid_o},  64'd0);
        check({tag, "_rready"},{63'd0, res_ready_o}, 64'd0);
    endtask

    initial begin
        logic [63:0] ab;
        wb_rst_ni   = 1'b0;
        pad_in_i    = '0;
        pad_stb_i   = 1'b0;
        op_ready_i  = 1'b0;
        res_i       = '0;
        res_valid_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check_all_zero("reset");
        wb_rst_ni = 1'b1;

        // Op 1: 1.0 + 2.0 with an always-ready adder.
        ab = 64'h3F800000_40000000;
        op_ready_i = 1'b1;
        load_range(ab, 0, 15);
        check("op1_a", {32'd0, op_a_o}, 64'h3F800000);
        check("op1_b", {32'd0, op_b_o}, 64'h40000000);
        check("op1_in_wait", {63'd0, res_ready_o}, 64'd1);
        check("op1_busy", {63'd0, pad_busy_o}, 64'd1);
        check("op1_valid_gone", {63'd0, op_valid_o}, 64'd0);
        give_result(32'h40400000);
        read_result(32'h40400000);

        // Op 2: backpressure for 10 cycles, res_valid raised in the handshake cycle.
        ab = 64'hDEADBEEF_01234567;
        op_ready_i = 1'b0;
        load_range(ab, 0, 15);
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            check("op2_valid_hold", {63'd0, op_valid_o}, 64'd1);
            check("op2_a_hold", {32'd0, op_a_o}, 64'hDEADBEEF);
            check("op2_b_hold", {32'd0, op_b_o}, 64'h01234567);
        end
        op_ready_i  = 1'b1;
        res_i       = 32'hC1234567;
        res_valid_i = 1'b1;
        @(negedge wb_clk_i);
        op_ready_i = 1'b0;
        check("op2_valid_drop", {63'd0, op_valid_o}, 64'd0);
        check("op2_wait", {63'd0, res_ready_o}, 64'd1);
        check("op2_no_early_capture", {63'd0, pad_rdy_o}, 64'd0);
        @(negedge wb_clk_i);
        res_valid_i = 1'b0;
        check("op2_captured", {63'd0, pad_rdy_o}, 64'd1);
        check("op2_rready_drop", {63'd0, res_ready_o}, 64'd0);
        read_result(32'hC1234567);

        // Op 3: strobe during WAIT is dropped and sets the sticky error.
        ab = 64'h11223344_55667788;
        op_ready_i = 1'b1;
        load_range(ab, 0, 15);
        check("op3_err_before", {63'd0, pad_err_o}, 64'd0);
        send_nibble(4'hF);
        check("op3_err_set", {63'd0, pad_err_o}, 64'd1);
        check("op3_a_kept", {32'd0, op_a_o}, 64'h11223344);
        check("op3_b_kept", {32'd0, op_b_o}, 64'h55667788);
        check("op3_still_wait", {63'd0, res_ready_o}, 64'd1);
        give_result(32'h89ABCDEF);
        read_result(32'h89ABCDEF);
        check("op3_err_sticky", {63'd0, pad_err_o}, 64'd1);

        // Op 4: full operation after the error, error must persist.
        ab = 64'hCAFEF00D_0BADC0DE;
        load_range(ab, 0, 15);
        check("op4_a", {32'd0, op_a_o}, 64'hCAFEF00D);
        check("op4_b", {32'd0, op_b_o}, 64'h0BADC0DE);
        give_result(32'h5A5A0F0F);
        read_result(32'h5A5A0F0F);
        check("op4_err_sticky", {63'd0, pad_err_o}, 64'd1);

        // Abort a load after 5 nibbles with reset.
        op_ready_i = 1'b0;
        ab = 64'hFFFFFFFF_FFFFFFFF;
        load_range(ab, 0, 4);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;

        // Op 5: first nibble strobe held 100 clocks must count once.
        ab = 64'h12345678_9ABCDEF0;
        send_nibble(nib_at(ab, 0), 100);
        check("long_stb_b", {32'd0, op_b_o}, 64'h1);
        check("long_stb_a", {32'd0, op_a_o}, 64'h0);
        send_nibble(nib_at(ab, 1));
        check("long_stb_next_b", {32'd0, op_b_o}, 64'h12);
        load_range(ab, 2, 14);
        check("op5_not_issued", {63'd0, op_valid_o}, 64'd0);
        load_range(ab, 15, 15);
        check("op5_issued", {63'd0, op_valid_o}, 64'd1);
        check("op5_a", {32'd0, op_a_o}, 64'h12345678);
        check("op5_b", {32'd0, op_b_o}, 64'h9ABCDEF0);
        check("op5_err_clear", {63'd0, pad_err_o}, 64'd0);
        @(negedge wb_clk_i);
        op_ready_i = 1'b1;
        @(negedge wb_clk_i);
        op_ready_i = 1'b0;
        check("op5_handshake", {63'd0, op_valid_o}, 64'd0);
        give_result(32'h3C00F1E2);
        read_result(32'h3C00F1E2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
